// File: rtl/unprotection.sv
// Receive-side unprotection cell: checks sequence numbers on protected words and
// reassembles payload slices into wide words. Optional error counter: UNPROT_ERRCNT_EN.
module unprotection #(
  parameter int unsigned PW    = 3,
  parameter int unsigned GROUP = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ENA,
  input  logic [1:0]          KEY,
  input  logic [7:0]          RGZ,
  output logic [PW*GROUP-1:0] RGD,
  output logic                VLD,
  output logic                ERR,
  output logic                LOCK,
  output logic [7:0]          ERRCNT
);

  localparam int unsigned OW = PW * GROUP;
  localparam int unsigned AW = PW * (GROUP - 1);
  localparam int unsigned CW = $clog2(GROUP + 1);

  typedef enum logic {
    HUNT = 1'b0,
    SYNC = 1'b1
  } state_t;

  state_t          state;
  logic [AW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic [2:0]      exp;

  logic [1:0]      ph;
  logic [2:0]      sq;
  logic [PW-1:0]   pl;
  logic            key_ok_c;
  logic            accept_c;
  logic            err_c;
  logic            last_c;
  logic [OW-1:0]   word_c;

  // Field split of the protected word
  assign ph = RGZ[7:6];
  assign sq = RGZ[5:3];
  assign pl = RGZ[PW-1:0];

  assign key_ok_c = (KEY == 2'b01);
  assign accept_c = ENA && key_ok_c && (ph == 2'b11);
  assign err_c    = accept_c && (state == SYNC) && (sq != exp);
  assign last_c   = (cnt == CW'(GROUP - 1));
  assign word_c   = {acc, pl};

  assign LOCK = (state == SYNC);

  // Sequence tracking, slice accumulation and output strobes
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= HUNT;
      acc   <= '0;
      cnt   <= '0;
      exp   <= 3'd0;
      RGD   <= '0;
      VLD   <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      VLD <= 1'b0;
      ERR <= 1'b0;
      if (!key_ok_c) begin
        // Disabled mode flushes any partial group silently; RGD is kept
        state <= HUNT;
        acc   <= '0;
        cnt   <= '0;
      end else if (accept_c) begin
        case (state)
          HUNT: begin
            acc   <= AW'(word_c);
            cnt   <= CW'(1);
            exp   <= sq + 3'd1;
            state <= SYNC;
          end
          SYNC: begin
            if (err_c) begin
              // Break restarts a group from this word; never merged with completion
              ERR <= 1'b1;
              acc <= AW'(pl);
              cnt <= CW'(1);
              exp <= sq + 3'd1;
            end else if (last_c) begin
              RGD <= word_c;
              VLD <= 1'b1;
              acc <= '0;
              cnt <= '0;
              exp <= exp + 3'd1;
            end else begin
              acc <= AW'(word_c);
              cnt <= cnt + CW'(1);
              exp <= exp + 3'd1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef UNPROT_ERRCNT_EN
  // Saturating count of sequence breaks, cleared only by reset
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ERRCNT <= 8'h00;
    end else if (err_c && (ERRCNT != 8'hFF)) begin
      ERRCNT <= ERRCNT + 8'h01;
    end
  end
`else
  assign ERRCNT = 8'h00;
`endif

endmodule

// File: tb/tb_unprotection.sv
// Directed self-checking bench for unprotection (default GROUP=4, 12-bit output).
module tb_unprotection;

  logic        CLK;
  logic        RST;
  logic        ENA;
  logic [1:0]  KEY;
  logic [7:0]  RGZ;
  logic [11:0] RGD;
  logic        VLD;
  logic        ERR;
  logic        LOCK;
  logic [7:0]  ERRCNT;

  int n_checks = 0;
  int n_errors = 0;

`ifdef UNPROT_ERRCNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  unprotection #(.PW(3), .GROUP(4)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .ENA    (ENA),
    .KEY    (KEY),
    .RGZ    (RGZ),
    .RGD    (RGD),
    .VLD    (VLD),
    .ERR    (ERR),
    .LOCK   (LOCK),
    .ERRCNT (ERRCNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // One clock with the given inputs, sampled 1 time unit after the edge
  task automatic step(input logic ena, input logic [1:0] key, input logic [7:0] w);
    @(negedge CLK);
    ENA = ena;
    KEY = key;
    RGZ = w;
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] w);
    step(1'b1, 2'b01, w);
  endtask

  task automatic flush();
    step(1'b1, 2'b00, 8'hC5);
    chk("flush_lock", 32'(LOCK), 32'd0);
  endtask

  function automatic logic [31:0] ecnt(input int n);
    return CNT_ON ? 32'(n) : 32'd0;
  endfunction

  initial begin
    RST = 1'b0;
    ENA = 1'b0;
    KEY = 2'b00;
    RGZ = 8'h00;
    #12;
    chk("rst_rgd", 32'(RGD), 32'h000);
    chk("rst_vld", 32'(VLD), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_lock", 32'(LOCK), 32'd0);
    chk("rst_errcnt", 32'(ERRCNT), 32'd0);
    @(negedge CLK);
    RST = 1'b1;

    // Basic group: 101 011 110 001
    send(8'hC5);
    chk("t1_lock", 32'(LOCK), 32'd1);
    chk("t1_vld0", 32'(VLD), 32'd0);
    send(8'hCB);
    send(8'hD6);
    chk("t1_vld_early", 32'(VLD), 32'd0);
    send(8'hD9);
    chk("t1_rgd", 32'(RGD), 32'hAF1);
    chk("t1_vld", 32'(VLD), 32'd1);
    chk("t1_err", 32'(ERR), 32'd0);
    step(1'b0, 2'b01, 8'hC5);
    chk("t1_vld_clear", 32'(VLD), 32'd0);
    chk("t1_rgd_hold", 32'(RGD), 32'hAF1);

    // Filler words interleaved
    flush();
    send(8'hC5);
    send(8'h45);
    chk("t2_fill_vld", 32'(VLD), 32'd0);
    send(8'hCB);
    send(8'h8B);
    send(8'hD6);
    send(8'h45);
    chk("t2_fill_err", 32'(ERR), 32'd0);
    send(8'hD9);
    chk("t2_rgd", 32'(RGD), 32'hAF1);
    chk("t2_vld", 32'(VLD), 32'd1);
    chk("t2_err", 32'(ERR), 32'd0);

    // Sequence break then recovery: 001 001 011 110
    flush();
    send(8'hC5);
    send(8'hCB);
    send(8'hD9);
    chk("t3_err", 32'(ERR), 32'd1);
    chk("t3_vld", 32'(VLD), 32'd0);
    chk("t3_errcnt", 32'(ERRCNT), ecnt(1));
    send(8'hE1);
    chk("t3_err_clear", 32'(ERR), 32'd0);
    send(8'hEB);
    send(8'hF6);
    chk("t3_rgd", 32'(RGD), 32'h25E);
    chk("t3_vld", 32'(VLD), 32'd1);

    // Sequence wrap 7->0: 101 001 010 011
    flush();
    send(8'hFD);
    send(8'hC1);
    chk("t4_wrap_err", 32'(ERR), 32'd0);
    send(8'hCA);
    send(8'hD3);
    chk("t4_rgd", 32'(RGD), 32'hA53);
    chk("t4_vld", 32'(VLD), 32'd1);
    chk("t4_err", 32'(ERR), 32'd0);

    // Mismatch on the would-be last slice: error wins, no completion
    send(8'hDD);
    send(8'hE6);
    send(8'hEF);
    send(8'hC0);
    chk("t5_err", 32'(ERR), 32'd1);
    chk("t5_vld", 32'(VLD), 32'd0);
    chk("t5_rgd_hold", 32'(RGD), 32'hA53);
    chk("t5_errcnt", 32'(ERRCNT), ecnt(2));

    // Disable mid-group: silent flush, rehunt: 110 001 101 011
    flush();
    send(8'hC5);
    send(8'hCB);
    step(1'b1, 2'b00, 8'hD6);
    chk("t6_gap_lock", 32'(LOCK), 32'd0);
    chk("t6_gap_err", 32'(ERR), 32'd0);
    chk("t6_gap_rgd", 32'(RGD), 32'hA53);
    send(8'hD6);
    chk("t6_relock", 32'(LOCK), 32'd1);
    send(8'hD9);
    send(8'hE5);
    send(8'hEB);
    chk("t6_rgd", 32'(RGD), 32'hC6B);
    chk("t6_vld", 32'(VLD), 32'd1);
    chk("t6_err", 32'(ERR), 32'd0);
    chk("t6_errcnt", 32'(ERRCNT), ecnt(2));

    // Asynchronous reset mid-group
    flush();
    send(8'hC5);
    send(8'hCB);
    send(8'hD6);
    #2;
    RST = 1'b0;
    #1;
    chk("t7_rst_rgd", 32'(RGD), 32'h000);
    chk("t7_rst_lock", 32'(LOCK), 32'd0);
    chk("t7_rst_vld", 32'(VLD), 32'd0);
    chk("t7_rst_errcnt", 32'(ERRCNT), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    send(8'hD9);
    chk("t7_lock", 32'(LOCK), 32'd1);
    chk("t7_vld", 32'(VLD), 32'd0);
    chk("t7_err", 32'(ERR), 32'd0);

    // ENA low: matching word ignored, expected SQ unchanged
    step(1'b0, 2'b01, 8'hE1);
    send(8'hE1);
    chk("t8_ena_err", 32'(ERR), 32'd0);
    chk("t8_ena_lock", 32'(LOCK), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected completion before 20000");
    $fatal(1, "timeout");
  end

endmodule
